// File: rtl/ife_pkg.sv
// ife_pkg: shared types for the IFE parallel receiver slice.
// Holds the receiver FSM state type, the register index width and the
// default block/instruction word types.
package ife_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMMIT
    } rx_state_e;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int BLOCK_ID_W_DEF = 8;
    localparam int INSTR_W_DEF    = 32;
    localparam int BLOCK_SIZE_DEF = 4;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [BLOCK_ID_W_DEF-1:0] block_id_t;
    typedef logic [INSTR_W_DEF-1:0]    instr_t;
    typedef instr_t [BLOCK_SIZE_DEF-1:0] block_t;

endpackage

// File: rtl/ife_parallel_receiver_if.sv
// ife_parallel_receiver_if: dispatch, core-control, writeback and commit
// signals of the IFE parallel receiver. master = IFE/core side, slave = receiver.
interface ife_parallel_receiver_if #(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUM_CORES      = 4,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64
);
    // dispatch side
    logic [BLOCK_ID_WIDTH-1:0]         disp_block_id;
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] disp_block;
    logic [NUM_CORES-1:0]              disp_mask;
    logic                              disp_valid;
    logic                              disp_ready;
    logic                              disp_drop;
    // core control
    logic [NUM_CORES-1:0]              core_start;
    logic [BLOCK_ID_WIDTH-1:0]         core_block_id;
    logic [BLOCK_SIZE*INSTR_WIDTH-1:0] core_block;
    logic [NUM_CORES-1:0]              core_done;
    logic [NUM_CORES-1:0]              core_busy;
    // writeback from the redundant pair, index 0 = core 0, 1 = core 1
    logic [1:0]                                  wb_en;
    logic [1:0][ife_pkg::REG_ADDR_WIDTH-1:0]     wb_addr;
    logic [1:0][REG_WIDTH-1:0]                   wb_data;
    // commit side
    logic [BLOCK_ID_WIDTH-1:0]         commit_block_id;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] result_0;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] result_1;
    logic                              commit_valid;
    logic                              abort;

    modport master (
        output disp_block_id, disp_block, disp_mask, disp_valid,
        output core_done, wb_en, wb_addr, wb_data,
        input  disp_ready, disp_drop, core_start, core_block_id, core_block,
        input  core_busy, commit_block_id, result_0, result_1, commit_valid, abort
    );

    modport slave (
        input  disp_block_id, disp_block, disp_mask, disp_valid,
        input  core_done, wb_en, wb_addr, wb_data,
        output disp_ready, disp_drop, core_start, core_block_id, core_block,
        output core_busy, commit_block_id, result_0, result_1, commit_valid, abort
    );

endinterface

// File: rtl/ife_shadow_regfile.sv
// ife_shadow_regfile: one shadow register file for a redundant core.
// Sync clear, single write port, x0 hard-wired to zero, whole array readable.
module ife_shadow_regfile
    import ife_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               we,
    input  reg_addr_t                          addr,
    input  logic [REG_WIDTH-1:0]               wdata,
    output logic [NUM_REGS-1:0][REG_WIDTH-1:0] rdata
);

    // clear has priority over write; index 0 is never written so x0 reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (we && addr != '0) begin
            rdata[addr] <= wdata;
        end
    end

endmodule

// File: rtl/ife_parallel_receiver.sv
// ife_parallel_receiver: core-side end of the IFE parallel dispatch path.
// Latches a dispatched block, pulses core_start to the selected cores, tracks
// completion, collects core 0/1 writebacks into two shadow files and pulses
// commit_valid when every selected core is done.
// Optional watchdog: define IFE_RX_TIMEOUT_EN to abort blocks that stay in
// RUN for TIMEOUT_CYCLES cycles.
module ife_parallel_receiver
    import ife_pkg::*;
#(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUM_CORES      = 4,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    ife_parallel_receiver_if.slave bus
);

    rx_state_e            state;
    logic [NUM_CORES-1:0] mask_q;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] pend_nxt;
    logic                 accept;
    logic                 in_run;

    // done pulses from cores outside the latched mask never touch pending
    assign pend_nxt = pending & ~(bus.core_done & mask_q);
    assign accept   = (state == IDLE) && bus.disp_valid && (bus.disp_mask != '0);
    assign in_run   = (state == RUN);

    assign bus.core_busy = pending;

`ifdef IFE_RX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_hit;

    assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign bus.abort      = 1'b0;
`endif

    // receiver FSM with registered pulses, latches and pending mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            mask_q              <= '0;
            pending             <= '0;
            bus.disp_ready      <= 1'b1;
            bus.disp_drop       <= 1'b0;
            bus.core_start      <= '0;
            bus.core_block_id   <= '0;
            bus.core_block      <= '0;
            bus.commit_block_id <= '0;
            bus.commit_valid    <= 1'b0;
`ifdef IFE_RX_TIMEOUT_EN
            bus.abort           <= 1'b0;
            wd_cnt              <= '0;
`endif
        end else begin
            bus.disp_drop    <= 1'b0;
            bus.core_start   <= '0;
            bus.commit_valid <= 1'b0;
`ifdef IFE_RX_TIMEOUT_EN
            bus.abort        <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state             <= RUN;
                        mask_q            <= bus.disp_mask;
                        pending           <= bus.disp_mask;
                        bus.core_start    <= bus.disp_mask;
                        bus.core_block_id <= bus.disp_block_id;
                        bus.core_block    <= bus.disp_block;
                        bus.disp_ready    <= 1'b0;
`ifdef IFE_RX_TIMEOUT_EN
                        wd_cnt            <= '0;
`endif
                    end
                end
                RUN: begin
                    bus.disp_drop <= bus.disp_valid;
                    pending       <= pend_nxt;
`ifdef IFE_RX_TIMEOUT_EN
                    wd_cnt        <= wd_cnt + 1'b1;
`endif
                    // completion is checked first so it wins over the watchdog
                    if (pend_nxt == '0) begin
                        state               <= COMMIT;
                        bus.commit_valid    <= 1'b1;
                        bus.commit_block_id <= bus.core_block_id;
                    end
`ifdef IFE_RX_TIMEOUT_EN
                    else if (wd_hit) begin
                        state          <= IDLE;
                        pending        <= '0;
                        bus.abort      <= 1'b1;
                        bus.disp_ready <= 1'b1;
                    end
`endif
                end
                COMMIT: begin
                    bus.disp_drop  <= bus.disp_valid;
                    state          <= IDLE;
                    bus.disp_ready <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.disp_ready <= 1'b1;
                end
            endcase
        end
    end

    // shadow files: cleared on accept, written only while RUN
    ife_shadow_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_WIDTH(REG_WIDTH)
    ) u_rf0 (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .we   (in_run && bus.wb_en[0]),
        .addr (bus.wb_addr[0]),
        .wdata(bus.wb_data[0]),
        .rdata(bus.result_0)
    );

    ife_shadow_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_WIDTH(REG_WIDTH)
    ) u_rf1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .we   (in_run && bus.wb_en[1]),
        .addr (bus.wb_addr[1]),
        .wdata(bus.wb_data[1]),
        .rdata(bus.result_1)
    );

endmodule

// File: tb/tb_ife_parallel_receiver.sv
// tb_ife_parallel_receiver: scoreboard bench for ife_parallel_receiver.
// Stimulus pushes expected start/drop/commit(/abort) events with their cycle;
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_ife_parallel_receiver;
    import ife_pkg::*;

    localparam int BW = 8;
    localparam int IW = 32;
    localparam int BS = 4;
    localparam int NC = 4;
    localparam int NR = 32;
    localparam int RW = 64;
`ifdef IFE_RX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    typedef struct {
        int                cyc;
        logic [NC-1:0]     mask;
        logic [BW-1:0]     id;
        logic [BS*IW-1:0]  blk;
    } start_t;

    typedef struct {
        int                         cyc;
        logic [BW-1:0]              id;
        logic [NR-1:0][RW-1:0]      r0;
        logic [NR-1:0][RW-1:0]      r1;
    } commit_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc_n = 0;
    int   n_vec = 0;
    int   n_err = 0;

    start_t  sq[$];
    commit_t cq[$];
    int      dq[$];
    int      aq[$];

    // reference model: what the commit unit should see
    logic [NR-1:0][RW-1:0] m0, m1;
    logic [NC-1:0]         m_pend;
    logic [BW-1:0]         m_id;

    ife_parallel_receiver_if #(
        .BLOCK_ID_WIDTH(BW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS),
        .NUM_CORES(NC), .NUM_REGS(NR), .REG_WIDTH(RW)
    ) bus ();

    ife_parallel_receiver #(
        .BLOCK_ID_WIDTH(BW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS),
        .NUM_CORES(NC), .NUM_REGS(NR), .REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_valid    = 1'b0;
        bus.disp_mask     = '0;
        bus.disp_block_id = '0;
        bus.disp_block    = '0;
        bus.core_done     = '0;
        bus.wb_en         = '0;
        bus.wb_addr       = '0;
        bus.wb_data       = '0;
    endtask

    // random writeback/done noise that must be ignored outside RUN
    task automatic noise();
        bus.core_done  = NC'($urandom);
        bus.wb_en      = 2'($urandom);
        bus.wb_addr[0] = 5'($urandom);
        bus.wb_addr[1] = 5'($urandom);
        bus.wb_data[0] = {$urandom, $urandom};
        bus.wb_data[1] = {$urandom, $urandom};
    endtask

    task automatic dispatch(input logic [BW-1:0] id, input logic [NC-1:0] mask);
        start_t s;
        chk("disp_ready_idle", bus.disp_ready, 1);
        chk("core_busy_idle", bus.core_busy, 0);
        noise();
        bus.disp_valid    = 1'b1;
        bus.disp_block_id = id;
        bus.disp_mask     = mask;
        bus.disp_block    = {$urandom, $urandom, $urandom, $urandom};
        s.cyc = cyc_n + 1; s.mask = mask; s.id = id; s.blk = bus.disp_block;
        sq.push_back(s);
        m_id = id; m_pend = mask; m0 = '0; m1 = '0;
        tick();
        idle_inputs();
    endtask

    task automatic zero_mask_cycle();
        noise();
        bus.disp_valid    = 1'b1;
        bus.disp_mask     = '0;
        bus.disp_block_id = BW'($urandom);
        tick();
        idle_inputs();
    endtask

    task automatic run_cycle(input logic [NC-1:0] done, input logic [1:0] wen,
                             input logic [4:0] a0, input logic [4:0] a1,
                             input logic [RW-1:0] d0, input logic [RW-1:0] d1,
                             input bit dv);
        commit_t c;
        chk("core_busy", bus.core_busy, m_pend);
        chk("disp_ready_busy", bus.disp_ready, 0);
        chk("core_block_id", bus.core_block_id, m_id);
        bus.core_done  = done;
        bus.wb_en      = wen;
        bus.wb_addr[0] = a0;
        bus.wb_addr[1] = a1;
        bus.wb_data[0] = d0;
        bus.wb_data[1] = d1;
        bus.disp_valid = dv;
        if (dv) begin
            bus.disp_mask     = NC'($urandom);
            bus.disp_block_id = BW'($urandom);
            dq.push_back(cyc_n + 1);
        end
        if (wen[0] && a0 != 0) m0[a0] = d0;
        if (wen[1] && a1 != 0) m1[a1] = d1;
        m_pend = m_pend & ~done;
        if (m_pend == 0) begin
            c.cyc = cyc_n + 1; c.id = m_id; c.r0 = m0; c.r1 = m1;
            cq.push_back(c);
        end
        tick();
        idle_inputs();
    endtask

    task automatic commit_cycle(input bit dv);
        chk("disp_ready_commit", bus.disp_ready, 0);
        noise();
        bus.disp_valid = dv;
        bus.disp_mask  = NC'($urandom);
        if (dv) dq.push_back(cyc_n + 1);
        tick();
        idle_inputs();
    endtask

    // monitor: pops an expectation whenever the DUT pulses an output
    always @(negedge clk) begin : mon
        start_t  s;
        commit_t c;
        if (!rst) begin
            if (sq.size() != 0 && sq[0].cyc < cyc_n) begin
                chk("core_start_missing", cyc_n, sq[0].cyc);
                void'(sq.pop_front());
            end
            if (cq.size() != 0 && cq[0].cyc < cyc_n) begin
                chk("commit_missing", cyc_n, cq[0].cyc);
                void'(cq.pop_front());
            end
            if (dq.size() != 0 && dq[0] < cyc_n) begin
                chk("disp_drop_missing", cyc_n, dq[0]);
                void'(dq.pop_front());
            end
            if (bus.core_start != '0) begin
                if (sq.size() == 0) chk("core_start_unexpected", bus.core_start, 0);
                else begin
                    s = sq.pop_front();
                    chk("core_start_cycle", cyc_n, s.cyc);
                    chk("core_start_mask", bus.core_start, s.mask);
                    chk("core_start_id", bus.core_block_id, s.id);
                    chk("core_start_block", bus.core_block, s.blk);
                end
            end
            if (bus.disp_drop) begin
                if (dq.size() == 0) chk("disp_drop_unexpected", bus.disp_drop, 0);
                else chk("disp_drop_cycle", cyc_n, dq.pop_front());
            end
            if (bus.commit_valid) begin
                if (cq.size() == 0) chk("commit_unexpected", bus.commit_valid, 0);
                else begin
                    c = cq.pop_front();
                    chk("commit_cycle", cyc_n, c.cyc);
                    chk("commit_block_id", bus.commit_block_id, c.id);
                    for (int r = 0; r < NR; r++) begin
                        chk($sformatf("result_0[%0d]", r), bus.result_0[r], c.r0[r]);
                        chk($sformatf("result_1[%0d]", r), bus.result_1[r], c.r1[r]);
                    end
                end
            end
`ifdef IFE_RX_TIMEOUT_EN
            if (aq.size() != 0 && aq[0] < cyc_n) begin
                chk("abort_missing", cyc_n, aq[0]);
                void'(aq.pop_front());
            end
            if (bus.abort) begin
                if (aq.size() == 0) chk("abort_unexpected", bus.abort, 0);
                else chk("abort_cycle", cyc_n, aq.pop_front());
            end
`else
            if (bus.abort) chk("abort_tied_low", bus.abort, 0);
`endif
        end
    end

    initial begin
        logic [NC-1:0] done;
        int            r;
        rst = 1'b1;
        idle_inputs();
        m0 = '0; m1 = '0; m_pend = '0; m_id = '0;
        tick();
        tick();
        chk("rst_disp_ready", bus.disp_ready, 1);
        chk("rst_core_busy", bus.core_busy, 0);
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_abort", bus.abort, 0);
        chk("rst_results", |{bus.result_0, bus.result_1}, 0);
        rst = 1'b0;
        tick();

        // basic block: both redundant cores finish together
        dispatch(8'h12, 4'b0011);
        run_cycle(4'b0011, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        commit_cycle(1'b0);

        // writebacks including an x0 write that must be discarded
        dispatch(8'h34, 4'b0011);
        run_cycle(4'b0000, 2'b11, 5'd5, 5'd5, 64'hAA, 64'hBB, 1'b0);
        run_cycle(4'b0000, 2'b11, 5'd0, 5'd0, 64'hFF, 64'hFF, 1'b0);
        run_cycle(4'b0011, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        commit_cycle(1'b0);
        chk("result_0_r5", bus.result_0[5], 64'hAA);
        chk("result_1_r5", bus.result_1[5], 64'hBB);
        chk("result_x0", {bus.result_0[0], bus.result_1[0]}, 0);

        // dispatch attempts while busy are dropped
        dispatch(8'h56, 4'b0001);
        run_cycle(4'b0000, 2'b00, 5'd0, 5'd0, '0, '0, 1'b1);
        run_cycle(4'b0001, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        commit_cycle(1'b1);

        // partial completion and out-of-mask done bits
        dispatch(8'h78, 4'b0011);
        run_cycle(4'b1100, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        run_cycle(4'b0001, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        run_cycle(4'b0000, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        run_cycle(4'b0010, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        commit_cycle(1'b0);

`ifdef IFE_RX_TIMEOUT_EN
        // core 1 never finishes: abort after TO cycles in RUN
        dispatch(8'h9A, 4'b0011);
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) aq.push_back(cyc_n + 1);
            run_cycle((i == 0) ? 4'b0001 : 4'b0000, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        end
        m_pend = '0;
        chk("abort_disp_ready", bus.disp_ready, 1);
        chk("abort_core_busy", bus.core_busy, 0);
        tick();
`endif

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 3) == 0) zero_mask_cycle();
            r = $urandom_range(1, NR - 1);
            chk("result_0_hold", bus.result_0[r], m0[r]);
            chk("result_1_hold", bus.result_1[r], m1[r]);
            dispatch(BW'($urandom), NC'($urandom_range(1, 15)));
            for (int k = 0; m_pend != 0; k++) begin
                done = (k >= 10) ? '1 : NC'($urandom & $urandom);
                run_cycle(done, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(0, 5) == 0);
            end
            commit_cycle($urandom_range(0, 3) == 0);
        end

        // async reset in the middle of a block
        dispatch(8'hC3, 4'b0111);
        run_cycle(4'b0000, 2'b11, 5'd3, 5'd4, 64'h11, 64'h22, 1'b0);
        run_cycle(4'b0001, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_disp_ready", bus.disp_ready, 1);
        chk("arst_core_busy", bus.core_busy, 0);
        chk("arst_core_block_id", bus.core_block_id, 0);
        chk("arst_pulses", {bus.core_start, bus.commit_valid, bus.disp_drop, bus.abort}, 0);
        chk("arst_results", |{bus.result_0, bus.result_1}, 0);
        m0 = '0; m1 = '0; m_pend = '0;
        tick();
        rst = 1'b0;
        tick();
        dispatch(8'h12, 4'b0011);
        run_cycle(4'b0011, 2'b00, 5'd0, 5'd0, '0, '0, 1'b0);
        commit_cycle(1'b0);

        tick();
        tick();
        chk("start_queue_empty", sq.size(), 0);
        chk("commit_queue_empty", cq.size(), 0);
        chk("drop_queue_empty", dq.size(), 0);
        chk("abort_queue_empty", aq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
